// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Two-requester, round-robin controller for an asynchronous single-port
//   SRAM with active-low N_WE / N_OE strobes (write commits on falling N_WE).
//   Each access is sequenced as SETUP -> strobe -> HOLD, so address and
//   write data are stable around every strobe edge. This block is the only
//   driver of the SRAM strobes.
//
// Ports
//   CLK, N_RST            clock (rising edge), synchronous active-low reset
//   REQ0/1, WE0/1         access request (held until GNT), 1 = write
//   ADDR0/1, WDATA0/1     access address / write data per requester
//   GNT0/1                combinational one-cycle accept (IDLE only)
//   RVALID0/1             one-cycle read-data-valid pulse to the owner
//   RDATA                 registered read data, shared between requesters
//   BUSY                  high whenever an access is in flight
//   SRAM_ADDR/SRAM_WDATA  address / write data to the SRAM
//   SRAM_N_WE/SRAM_N_OE   registered active-low strobes to the SRAM
//   SRAM_RDATA            read data from the SRAM
module sram_arbiter #(
  parameter int DEPTH    = 12,
  parameter int WIDTH    = 8,
  parameter int RD_WAIT  = 1,
  parameter int WR_PULSE = 1
) (
  input  logic             CLK,
  input  logic             N_RST,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic             WE0,
  input  logic             WE1,
  input  logic [DEPTH-1:0] ADDR0,
  input  logic [DEPTH-1:0] ADDR1,
  input  logic [WIDTH-1:0] WDATA0,
  input  logic [WIDTH-1:0] WDATA1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             RVALID0,
  output logic             RVALID1,
  output logic [WIDTH-1:0] RDATA,
  output logic             BUSY,
  output logic [DEPTH-1:0] SRAM_ADDR,
  output logic             SRAM_N_WE,
  output logic             SRAM_N_OE,
  output logic [WIDTH-1:0] SRAM_WDATA,
  input  logic [WIDTH-1:0] SRAM_RDATA
);

  // Strobe-length counter only needs to reach the longer of the two pulses.
  localparam int MAX_PULSE = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
  localparam int CNT_W     = (MAX_PULSE > 1) ? $clog2(MAX_PULSE) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WSTROBE,
    RSTROBE,
    HOLD
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             owner;      // requester that owns the current access
  logic             we_q;       // latched access direction
  logic             last_gnt;   // requester granted most recently
  logic             grant0;
  logic             grant1;
  logic             strobe_last;

  // Arbitration: a lone requester wins; on a tie the requester that was not
  // granted last wins. Grants are suppressed while reset is asserted so no
  // accept is signalled at an edge that will be discarded.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && N_RST) begin
      if (REQ0 && (!REQ1 || last_gnt)) grant0 = 1'b1;
      else if (REQ1)                   grant1 = 1'b1;
    end
  end

  assign GNT0 = grant0;
  assign GNT1 = grant1;
  assign BUSY = (state != IDLE);

  // Last cycle of the strobe phase for the current access direction.
  always_comb begin
    strobe_last = 1'b0;
    if (state == WSTROBE && cnt == CNT_W'(WR_PULSE - 1)) strobe_last = 1'b1;
    if (state == RSTROBE && cnt == CNT_W'(RD_WAIT - 1))  strobe_last = 1'b1;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant0 || grant1) next_state = SETUP;
      SETUP:   next_state = we_q ? WSTROBE : RSTROBE;
      WSTROBE,
      RSTROBE: if (strobe_last) next_state = HOLD;
      HOLD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!N_RST) begin
      // NOTE: the SRAM-facing address/data registers are reset too, so the
      // pins come up at a defined value rather than whatever the flops hold.
      state      <= IDLE;
      cnt        <= '0;
      owner      <= 1'b0;
      we_q       <= 1'b0;
      last_gnt   <= 1'b1;    // requester 0 wins the first tie
      SRAM_ADDR  <= '0;
      SRAM_WDATA <= '0;
      SRAM_N_WE  <= 1'b1;
      SRAM_N_OE  <= 1'b1;
      RDATA      <= '0;
      RVALID0    <= 1'b0;
      RVALID1    <= 1'b0;
    end else begin
      state <= next_state;

      if ((state == WSTROBE || state == RSTROBE) && !strobe_last) cnt <= cnt + 1'b1;
      else                                                         cnt <= '0;

      // Request fields are captured at the grant edge, which is also the
      // only edge on which the SRAM address/data pins may change.
      if (grant0 || grant1) begin
        owner      <= grant1;
        last_gnt   <= grant1;
        we_q       <= grant1 ? WE1    : WE0;
        SRAM_ADDR  <= grant1 ? ADDR1  : ADDR0;
        SRAM_WDATA <= grant1 ? WDATA1 : WDATA0;
      end

      // Strobes are decoded from the next state so each flop toggles exactly
      // on state entry/exit; they can never both be low.
      SRAM_N_WE <= (next_state != WSTROBE);
      SRAM_N_OE <= (next_state != RSTROBE);

      if (state == RSTROBE && strobe_last) RDATA <= SRAM_RDATA;

      RVALID0 <= (next_state == HOLD) && !we_q && !owner;
      RVALID1 <= (next_state == HOLD) && !we_q &&  owner;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed and random bench for sram_arbiter. dut_a uses default timing,
// dut_b uses RD_WAIT=3 / WR_PULSE=2; each drives a behavioural SRAM that
// commits on the falling edge of N_WE and drives data only while N_OE is low.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- dut_a (default parameters) ----------------
  logic        a_req0 = 0, a_req1 = 0, a_we0 = 0, a_we1 = 0;
  logic [11:0] a_addr0 = 0, a_addr1 = 0;
  logic [7:0]  a_wdata0 = 0, a_wdata1 = 0;
  logic        a_gnt0, a_gnt1, a_rv0, a_rv1, a_busy, a_n_we, a_n_oe;
  logic [7:0]  a_rdata, a_sram_wdata, a_sram_rdata;
  logic [11:0] a_sram_addr;
  logic [7:0]  a_mem [4096];

  sram_arbiter dut_a (
    .CLK(clk), .N_RST(n_rst),
    .REQ0(a_req0), .REQ1(a_req1), .WE0(a_we0), .WE1(a_we1),
    .ADDR0(a_addr0), .ADDR1(a_addr1), .WDATA0(a_wdata0), .WDATA1(a_wdata1),
    .GNT0(a_gnt0), .GNT1(a_gnt1), .RVALID0(a_rv0), .RVALID1(a_rv1),
    .RDATA(a_rdata), .BUSY(a_busy), .SRAM_ADDR(a_sram_addr),
    .SRAM_N_WE(a_n_we), .SRAM_N_OE(a_n_oe), .SRAM_WDATA(a_sram_wdata),
    .SRAM_RDATA(a_sram_rdata)
  );

  always @(negedge a_n_we) if (n_rst === 1'b1) a_mem[a_sram_addr] = a_sram_wdata;
  assign a_sram_rdata = a_n_oe ? 8'h00 : a_mem[a_sram_addr];

  // ---------------- dut_b (long strobes) ----------------
  logic        b_req0 = 0, b_req1 = 0, b_we0 = 0, b_we1 = 0;
  logic [11:0] b_addr0 = 0, b_addr1 = 0;
  logic [7:0]  b_wdata0 = 0, b_wdata1 = 0;
  logic        b_gnt0, b_gnt1, b_rv0, b_rv1, b_busy, b_n_we, b_n_oe;
  logic [7:0]  b_rdata, b_sram_wdata, b_sram_rdata;
  logic [11:0] b_sram_addr;
  logic [7:0]  b_mem [4096];

  sram_arbiter #(.DEPTH(12), .WIDTH(8), .RD_WAIT(3), .WR_PULSE(2)) dut_b (
    .CLK(clk), .N_RST(n_rst),
    .REQ0(b_req0), .REQ1(b_req1), .WE0(b_we0), .WE1(b_we1),
    .ADDR0(b_addr0), .ADDR1(b_addr1), .WDATA0(b_wdata0), .WDATA1(b_wdata1),
    .GNT0(b_gnt0), .GNT1(b_gnt1), .RVALID0(b_rv0), .RVALID1(b_rv1),
    .RDATA(b_rdata), .BUSY(b_busy), .SRAM_ADDR(b_sram_addr),
    .SRAM_N_WE(b_n_we), .SRAM_N_OE(b_n_oe), .SRAM_WDATA(b_sram_wdata),
    .SRAM_RDATA(b_sram_rdata)
  );

  always @(negedge b_n_we) if (n_rst === 1'b1) b_mem[b_sram_addr] = b_sram_wdata;
  assign b_sram_rdata = b_n_oe ? 8'h00 : b_mem[b_sram_addr];

  // Selected-DUT view used by the shared access task.
  // status = {busy, n_we, n_oe, gnt0, gnt1, rvalid0, rvalid1}
  logic        use_b = 1'b0;
  logic [6:0]  m_status;
  logic [11:0] m_addr;
  logic [7:0]  m_wdata, m_rdata;

  always_comb begin
    m_status = use_b ? {b_busy, b_n_we, b_n_oe, b_gnt0, b_gnt1, b_rv0, b_rv1}
                     : {a_busy, a_n_we, a_n_oe, a_gnt0, a_gnt1, a_rv0, a_rv1};
    m_addr   = use_b ? b_sram_addr  : a_sram_addr;
    m_wdata  = use_b ? b_sram_wdata : a_sram_wdata;
    m_rdata  = use_b ? b_rdata      : a_rdata;
  end

  // Expected status k cycles after the grant cycle for a strobe of len
  // cycles: grant at 0, SETUP at 1, strobe 2..1+len, HOLD 2+len, IDLE after.
  function automatic logic [6:0] exp_status(int k, bit who, bit we, int len);
    bit busy, gnt, strobe, hold;
    busy   = (k >= 1) && (k <= 2 + len);
    gnt    = (k == 0);
    strobe = (k >= 2) && (k <= 1 + len);
    hold   = (k == 2 + len);
    return {busy, !(strobe && we), !(strobe && !we), gnt && !who, gnt && who,
            hold && !we && !who, hold && !we && who};
  endfunction

  // Issue one access on the selected DUT (called just after a rising edge,
  // with the DUT idle) and check every cycle until it is idle again.
  task automatic do_access(input bit sel, input bit who, input bit we,
                           input logic [11:0] addr, input logic [7:0] data,
                           input logic [7:0] exp_rd, input string name);
    int len;
    logic [7:0] mem_val;
    len   = sel ? (we ? 2 : 3) : 1;
    use_b = sel;
    if (sel) begin
      b_req0 = 1; b_we0 = we; b_addr0 = addr; b_wdata0 = data;
    end else if (!who) begin
      a_req0 = 1; a_we0 = we; a_addr0 = addr; a_wdata0 = data;
    end else begin
      a_req1 = 1; a_we1 = we; a_addr1 = addr; a_wdata1 = data;
    end
    for (int k = 0; k <= 3 + len; k++) begin
      @(negedge clk);
      n_checks++;
      if (m_status !== exp_status(k, who, we, len)) begin
        n_fail++;
        $display("FAIL %s status k=%0d: got %b want %b", name, k, m_status,
                 exp_status(k, who, we, len));
      end
      if (k >= 1 && k <= 2 + len) begin
        n_checks++;
        if ({m_addr, m_wdata} !== {addr, data}) begin
          n_fail++;
          $display("FAIL %s addr/data k=%0d: got %h/%h want %h/%h", name, k,
                   m_addr, m_wdata, addr, data);
        end
      end
      if (k == 2 + len && !we) begin
        n_checks++;
        if (m_rdata !== exp_rd) begin
          n_fail++;
          $display("FAIL %s rdata: got %h want %h", name, m_rdata, exp_rd);
        end
      end
      @(posedge clk); #1;
      if (k == 0) begin
        a_req0 = 0; a_req1 = 0; b_req0 = 0;
      end
    end
    if (we) begin
      mem_val = sel ? b_mem[addr] : a_mem[addr];
      n_checks++;
      if (mem_val !== data) begin
        n_fail++;
        $display("FAIL %s sram_mem[%h]: got %h want %h", name, addr, mem_val, data);
      end
    end
    use_b = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 0;
    a_req0 = 1; a_req1 = 1; b_req0 = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({a_busy, a_n_we, a_n_oe, a_gnt0, a_gnt1, a_rv0, a_rv1} !== 7'b0110000) begin
      n_fail++;
      $display("FAIL reset_status_a: got %b want 0110000",
               {a_busy, a_n_we, a_n_oe, a_gnt0, a_gnt1, a_rv0, a_rv1});
    end
    n_checks++;
    if ({a_rdata, a_sram_addr, a_sram_wdata} !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_regs_a: got %h/%h/%h want 0/0/0", a_rdata, a_sram_addr, a_sram_wdata);
    end
    n_checks++;
    if ({b_busy, b_n_we, b_n_oe, b_gnt0, b_gnt1, b_rv0, b_rv1} !== 7'b0110000) begin
      n_fail++;
      $display("FAIL reset_status_b: got %b want 0110000",
               {b_busy, b_n_we, b_n_oe, b_gnt0, b_gnt1, b_rv0, b_rv1});
    end
    @(posedge clk); #1;
    a_req0 = 0; a_req1 = 0; b_req0 = 0;
    n_rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    do_access(0, 0, 1, 12'h123, 8'hA5, 8'h00, "wr0_123");
    do_access(0, 1, 0, 12'h123, 8'h00, 8'hA5, "rd1_123");
  endtask

  task automatic test_back_to_back();
    int ng = 0;
    int nr = 0;
    do_access(0, 0, 1, 12'h010, 8'h5A, 8'h00, "wr0_010");
    do_access(0, 1, 1, 12'h011, 8'hC3, 8'h00, "wr1_011");
    // Requester 1 was granted last, so contention starts with requester 0.
    a_req0 = 1; a_we0 = 0; a_addr0 = 12'h010; a_wdata0 = 8'h00;
    a_req1 = 1; a_we1 = 0; a_addr1 = 12'h011; a_wdata1 = 8'h00;
    for (int c = 0; c < 60 && nr < 4; c++) begin
      @(negedge clk);
      if (a_gnt0 || a_gnt1) begin
        n_checks++;
        if ({a_gnt0, a_gnt1} !== (ng[0] ? 2'b01 : 2'b10)) begin
          n_fail++;
          $display("FAIL rr_gnt#%0d: got %b want %b", ng, {a_gnt0, a_gnt1},
                   ng[0] ? 2'b01 : 2'b10);
        end
        ng++;
      end
      if (a_rv0 || a_rv1) begin
        n_checks++;
        if ({a_rv0, a_rv1, a_rdata} !== (nr[0] ? {2'b01, 8'hC3} : {2'b10, 8'h5A})) begin
          n_fail++;
          $display("FAIL rr_rvalid#%0d: got %b/%h want %s", nr, {a_rv0, a_rv1}, a_rdata,
                   nr[0] ? "01/c3" : "10/5a");
        end
        nr++;
      end
      @(posedge clk); #1;
      if (ng >= 4) begin
        a_req0 = 0; a_req1 = 0;
      end
    end
    n_checks++;
    if (nr != 4) begin
      n_fail++;
      $display("FAIL rr_timeout: got %0d read completions want 4", nr);
    end
  endtask

  task automatic test_long_strobes();
    do_access(1, 0, 1, 12'h001, 8'h3C, 8'h00, "b_wr_001");
    do_access(1, 0, 0, 12'h001, 8'h00, 8'h3C, "b_rd_001");
  endtask

  task automatic test_reset_abort();
    a_req0 = 1; a_we0 = 0; a_addr0 = 12'h123; a_wdata0 = 8'h00;
    @(negedge clk);
    n_checks++;
    if (a_gnt0 !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_gnt: got %b want 1", a_gnt0);
    end
    @(posedge clk); #1;
    a_req0 = 0;
    @(posedge clk); #1;   // now in RSTROBE
    @(negedge clk);
    n_checks++;
    if (a_n_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_rstrobe: n_oe got %b want 0", a_n_oe);
    end
    n_rst = 0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({a_busy, a_n_we, a_n_oe, a_rv0, a_rv1, a_rdata} !== {5'b01100, 8'h00}) begin
      n_fail++;
      $display("FAIL abort_state: got %b/%h want 01100/00",
               {a_busy, a_n_we, a_n_oe, a_rv0, a_rv1}, a_rdata);
    end
    @(posedge clk); #1;
    n_rst = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({a_busy, a_rv0, a_rv1} !== 3'b000) begin
        n_fail++;
        $display("FAIL abort_quiet c=%0d: got %b want 000", c, {a_busy, a_rv0, a_rv1});
      end
      @(posedge clk); #1;
    end
    do_access(0, 0, 0, 12'h123, 8'h00, 8'hA5, "rd0_after_rst");
  endtask

  task automatic test_random();
    logic [7:0]  ref_mem [16];
    bit          pend_owner, have_last, last_w, w, both;
    logic [7:0]  pend_data;
    logic [11:0] g_addr;
    logic [7:0]  g_data;
    bit          g_we, drop0, drop1;
    int          reads_issued = 0;
    int          reads_done   = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    have_last = 0; pend_owner = 0; pend_data = 8'h00;
    for (int cyc = 0; cyc < 10040; cyc++) begin
      if (cyc < 10000) begin
        if (!a_req0 && $urandom_range(0, 1) == 1) begin
          a_req0 = 1; a_we0 = 1'($urandom_range(0, 1));
          a_addr0 = 12'h200 | 12'($urandom_range(0, 15)); a_wdata0 = 8'($urandom);
        end
        if (!a_req1 && $urandom_range(0, 1) == 1) begin
          a_req1 = 1; a_we1 = 1'($urandom_range(0, 1));
          a_addr1 = 12'h200 | 12'($urandom_range(0, 15)); a_wdata1 = 8'($urandom);
        end
      end
      drop0 = 0; drop1 = 0;
      @(negedge clk);
      n_checks++;
      if ({!a_n_we && !a_n_oe, a_gnt0 && a_gnt1, a_rv0 && a_rv1} !== 3'b000) begin
        n_fail++;
        $display("FAIL rand_invariant cyc=%0d: n_we=%b n_oe=%b gnt=%b%b rv=%b%b",
                 cyc, a_n_we, a_n_oe, a_gnt0, a_gnt1, a_rv0, a_rv1);
      end
      if (a_gnt0 || a_gnt1) begin
        w    = a_gnt1;
        both = a_req0 && a_req1;
        if (both && have_last) begin
          n_checks++;
          if (w === last_w) begin
            n_fail++;
            $display("FAIL rand_rr cyc=%0d: got winner %0d want %0d", cyc, w, !last_w);
          end
        end
        have_last = 1; last_w = w;
        g_we   = w ? a_we1   : a_we0;
        g_addr = w ? a_addr1 : a_addr0;
        g_data = w ? a_wdata1 : a_wdata0;
        if (g_we) ref_mem[g_addr[3:0]] = g_data;
        else begin
          pend_owner = w; pend_data = ref_mem[g_addr[3:0]]; reads_issued++;
        end
        if (w) drop1 = 1; else drop0 = 1;
      end
      if (a_rv0 || a_rv1) begin
        n_checks++;
        if ({a_rv1, a_rdata} !== {pend_owner, pend_data}) begin
          n_fail++;
          $display("FAIL rand_read cyc=%0d: got owner %0d data %h want owner %0d data %h",
                   cyc, a_rv1, a_rdata, pend_owner, pend_data);
        end
        reads_done++;
      end
      @(posedge clk); #1;
      if (drop0) a_req0 = 0;
      if (drop1) a_req1 = 0;
    end
    n_checks++;
    if (reads_done != reads_issued || a_req0 || a_req1) begin
      n_fail++;
      $display("FAIL rand_drain: got %0d reads done want %0d (req %b%b)",
               reads_done, reads_issued, a_req0, a_req1);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      a_mem[i] = 8'h00;
      b_mem[i] = 8'h00;
    end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_long_strobes();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester controller for the asynchronous single-port SRAM (active-low N_WE/N_OE strobes, write on falling N_WE).
- Arbitrates round-robin between requester 0 (e.g. CPU) and requester 1 (e.g. loader/debug).
- Sequences each access as setup, strobe and hold, so address and data are stable around every strobe edge.
- Sits between the bus masters and the SRAM instance; it is the only driver of the SRAM strobes.

Parameters:
DEPTH, 12, SRAM address width
WIDTH, 8, SRAM data width
RD_WAIT, 1, cycles N_OE held low per read (>=1)
WR_PULSE, 1, cycles N_WE held low per write (>=1)

Ports:
CLK  in  1  system clock; all logic on rising edge
N_RST  in  1  synchronous active-low reset
REQ0 / REQ1  in  1  access request; held with its fields until its GNT
WE0 / WE1  in  1  1 = write, 0 = read
ADDR0 / ADDR1  in  DEPTH  access address
WDATA0 / WDATA1  in  WIDTH  write data
GNT0 / GNT1  out  1  combinational one-cycle accept; request fields latched this edge
RVALID0 / RVALID1  out  1  one-cycle read-data-valid pulse to the owning requester
RDATA  out  WIDTH  registered read data, shared; valid while the owner's RVALID is high
BUSY  out  1  1 whenever state != IDLE
SRAM_ADDR  out  DEPTH  to SRAM ADDR
SRAM_N_WE  out  1  to SRAM N_WE; flop output
SRAM_N_OE  out  1  to SRAM N_OE; flop output
SRAM_WDATA  out  WIDTH  to SRAM IN_DATA
SRAM_RDATA  in  WIDTH  from SRAM OUT_DATA

Behaviour:
Reset (N_RST=0 at an edge):
- State -> IDLE.
- SRAM_N_WE=1, SRAM_N_OE=1; GNT*=0, RVALID*=0, BUSY=0.
- RDATA=0, SRAM_ADDR=0, SRAM_WDATA=0.
- Round-robin pointer set so requester 0 wins the first tie.
- Reset mid-access aborts it: strobes go high at that edge, no RVALID is issued, and the aborted requester gets no further response.
- A write whose N_WE already fell has been committed.

FSM states: IDLE, SETUP, WSTROBE, RSTROBE, HOLD.
- IDLE: if any REQ is high, GNT the winner combinationally.
  - At that edge, latch owner, WE, ADDR and WDATA, update the pointer, and go to SETUP.
  - No GNT is issued in any state other than IDLE.
- SETUP (1 cycle): SRAM_ADDR/SRAM_WDATA are driven from the latched values and both strobes are high. Next state is WSTROBE or RSTROBE.
- WSTROBE (WR_PULSE cycles): SRAM_N_WE=0, then go to HOLD.
- RSTROBE (RD_WAIT cycles): SRAM_N_OE=0. On the last cycle's edge, capture SRAM_RDATA into RDATA, then go to HOLD.
- HOLD (1 cycle): both strobes high; address and data are unchanged. For reads, RVALIDx=1 for this cycle. Then go to IDLE.
- Strobe flops are loaded from next-state decode so their edges align with state entry and exit; no combinational glitches.

Latency (GNT at cycle t):
- Read: N_OE low over t+2..t+1+RD_WAIT; RVALID at t+2+RD_WAIT.
- Write: N_WE low over t+2..t+1+WR_PULSE; HOLD at t+2+WR_PULSE.
- Next GNT is possible at t+3+RD_WAIT (read) or t+3+WR_PULSE (write).

Arbitration:
- Only one requester high: it wins.
- Both high: the requester not granted last wins, so back-to-back contention alternates 0,1,0,1.
- The pointer updates only on grant.

Invariants:
- SRAM_N_WE and SRAM_N_OE are never both 0.
- SRAM_ADDR/SRAM_WDATA change only on entry to SETUP, and are stable from SETUP through HOLD inclusive.
- At most one GNT and at most one RVALID per cycle.
- RDATA is unchanged except at the capture edge.

Test Plan:
- Reset, REQ0 write ADDR0=0x123 WDATA0=0xA5 (defaults) -> GNT0 at t; N_WE low exactly at t+2; SETUP/HOLD strobes high; address/data stable t+1..t+3; SRAM model holds 0xA5 at 0x123.
- Then REQ1 read 0x123 -> GNT1; N_OE low at t+2; RVALID1 at t+3 with RDATA=0xA5; RVALID0 stays 0.
- REQ0 and REQ1 both held high with reads for 4 grants -> GNT order 0,1,0,1; each access ends with RVALID to the correct owner.
- RD_WAIT=3, WR_PULSE=2: write 0x3C to 0x001, then read it -> N_WE low 2 cycles, N_OE low 3 cycles, RVALID at t+5, RDATA=0x3C.
- N_RST=0 during RSTROBE -> next cycle strobes high, BUSY=0, no RVALID; a fresh REQ0 read after release completes normally.
- Random REQ/WE traffic for 10k cycles -> never N_WE=N_OE=0; every read returns the last data written to that address per a reference model.
